// File: rtl/acc_wb_arbiter_pkg.sv
// Shared definitions for the accelerator-port Wishbone arbiter: state encoding,
// master indices, error read data and the request payload bundle.
package acc_wb_arbiter_pkg;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int unsigned M0_IDX = 0;
  localparam int unsigned M1_IDX = 1;

  localparam logic [DW-1:0] ACC_ERR_RDT = 32'h0;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic          we;
    logic          cyc;
  } wb_req_t;

endpackage

// File: rtl/acc_wdt.sv
// Loadable watchdog counter; expire_c flags the last allowed cycle (LIMIT-1).
// LIMIT of 0 disables expiry entirely.
module acc_wdt #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic         expire_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire_c = (LIMIT != 0) && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/acc_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter for the accelerator slave port, with a
// watchdog that terminates cycles the slave never acknowledges.
module acc_wb_arbiter
  import acc_wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic [31:0] i_m0_adr,
  input  logic [31:0] i_m0_dat,
  input  logic        i_m0_we,
  input  logic        i_m0_cyc,
  output logic [31:0] o_m0_rdt,
  output logic        o_m0_ack,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  input  logic        i_m1_we,
  input  logic        i_m1_cyc,
  output logic [31:0] o_m1_rdt,
  output logic        o_m1_ack,
  output logic [31:0] o_acc_adr,
  output logic [31:0] o_acc_dat,
  output logic        o_acc_we,
  output logic        o_acc_cyc,
  input  logic [31:0] i_acc_rdt,
  input  logic        i_acc_ack,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [0:0]    state, state_nxt;
  logic [1:0]    grant, grant_nxt;
  logic          last_m1, last_m1_nxt;
  logic          timeout_q, timeout_nxt;
  logic          done_c;
  logic          mst_ack;
  logic [DW-1:0] mst_rdt;
  logic          wdt_load, wdt_inc, wdt_expire_c;
  wb_req_t       m0_req, m1_req, sel_req;

  assign m0_req  = '{adr: i_m0_adr, dat: i_m0_dat, we: i_m0_we, cyc: i_m0_cyc};
  assign m1_req  = '{adr: i_m1_adr, dat: i_m1_dat, we: i_m1_we, cyc: i_m1_cyc};
  assign sel_req = grant[M1_IDX] ? m1_req : m0_req;

  acc_wdt #(
    .LIMIT (TIMEOUT),
    .W     (CW)
  ) u_wdt (
    .clk      (i_wb_clk),
    .rst_n    (i_wb_rst_n),
    .load     (wdt_load),
    .load_val ('0),
    .inc      (wdt_inc),
    .expire_c (wdt_expire_c)
  );

  // State, owner and round-robin pointer; last_m1=1 gives M0 priority.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state     <= ST_IDLE;
      grant     <= 2'b00;
      last_m1   <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      last_m1   <= last_m1_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  // Arbitration, slave-side muxing and termination of the current transaction.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    last_m1_nxt = last_m1;
    timeout_nxt = timeout_q;
    done_c      = 1'b0;
    mst_ack     = 1'b0;
    mst_rdt     = '0;
    wdt_load    = 1'b0;
    wdt_inc     = 1'b0;
    o_acc_adr   = '0;
    o_acc_dat   = '0;
    o_acc_we    = 1'b0;
    o_acc_cyc   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_m0_cyc || i_m1_cyc) begin
          state_nxt = ST_BUSY;
          wdt_load  = 1'b1;
          if (i_m0_cyc && i_m1_cyc) begin
            grant_nxt = last_m1 ? 2'b01 : 2'b10;
          end else begin
            grant_nxt = i_m1_cyc ? 2'b10 : 2'b01;
          end
        end
      end
      ST_BUSY: begin
        o_acc_adr = sel_req.adr;
        o_acc_dat = sel_req.dat;
        o_acc_we  = sel_req.we;
        o_acc_cyc = sel_req.cyc;
        if (!sel_req.cyc) begin
          done_c = 1'b1;
        end else if (i_acc_ack) begin
          mst_ack = 1'b1;
          mst_rdt = i_acc_rdt;
          done_c  = 1'b1;
        end else if (wdt_expire_c) begin
          o_acc_cyc   = 1'b0;
          mst_ack     = 1'b1;
          mst_rdt     = ACC_ERR_RDT;
          timeout_nxt = 1'b1;
          done_c      = 1'b1;
        end else begin
          wdt_inc = 1'b1;
        end
        if (done_c) begin
          state_nxt   = ST_IDLE;
          grant_nxt   = 2'b00;
          last_m1_nxt = grant[M1_IDX];
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  assign o_m0_ack  = mst_ack & grant[M0_IDX];
  assign o_m1_ack  = mst_ack & grant[M1_IDX];
  assign o_m0_rdt  = grant[M0_IDX] ? mst_rdt : '0;
  assign o_m1_rdt  = grant[M1_IDX] ? mst_rdt : '0;
  assign o_grant   = grant;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_acc_wb_arbiter.sv
// Bench for acc_wb_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_acc_wb_arbiter;

  localparam int TO = 8;
  localparam logic [31:0] A0  = 32'h1000_0000;
  localparam logic [31:0] D0  = 32'h1111_0000;
  localparam logic [31:0] A1  = 32'h4000_0010;
  localparam logic [31:0] D1  = 32'hDEAD_0002;
  localparam logic [31:0] RDT = 32'hA5A5_0001;

  logic        clk, rst_n;
  logic [31:0] i_m0_adr, i_m0_dat, o_m0_rdt, i_m1_adr, i_m1_dat, o_m1_rdt;
  logic        i_m0_we, i_m0_cyc, o_m0_ack, i_m1_we, i_m1_cyc, o_m1_ack;
  logic [31:0] o_acc_adr, o_acc_dat, i_acc_rdt;
  logic        o_acc_we, o_acc_cyc, i_acc_ack, o_timeout;
  logic [1:0]  o_grant;

  acc_wb_arbiter #(.TIMEOUT(TO)) dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n),
    .i_m0_adr(i_m0_adr), .i_m0_dat(i_m0_dat), .i_m0_we(i_m0_we), .i_m0_cyc(i_m0_cyc),
    .o_m0_rdt(o_m0_rdt), .o_m0_ack(o_m0_ack),
    .i_m1_adr(i_m1_adr), .i_m1_dat(i_m1_dat), .i_m1_we(i_m1_we), .i_m1_cyc(i_m1_cyc),
    .o_m1_rdt(o_m1_rdt), .o_m1_ack(o_m1_ack),
    .o_acc_adr(o_acc_adr), .o_acc_dat(o_acc_dat), .o_acc_we(o_acc_we), .o_acc_cyc(o_acc_cyc),
    .i_acc_rdt(i_acc_rdt), .i_acc_ack(i_acc_ack),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit rst; bit m0; bit m1; bit ack;
    bit e_cyc; bit e_a0; bit e_a1; logic [1:0] e_g; logic [31:0] e_adr;
  } vec_t;
  vec_t vt[$];

  // reference model state (owner -1 = idle)
  int owner, last, waited;
  bit sticky;
  int thr;
  int thr_tab[3] = '{0, 3, 12};
  logic [134:0] act_v, exp_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit m0, input bit m1, input bit ack);
    i_m0_cyc  = m0;
    i_m1_cyc  = m1;
    i_acc_ack = ack;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_m0_adr = A0; i_m0_dat = D0; i_m0_we = 1'b0;
    i_m1_adr = A1; i_m1_dat = D1; i_m1_we = 1'b1;
    i_acc_rdt = RDT;
    set_in(0, 0, 0);
    #1;
    check("reset acc_cyc", 32'(o_acc_cyc), 0);
    check("reset grant", 32'(o_grant), 0);
    check("reset timeout", 32'(o_timeout), 0);
    check("reset acks", 32'({o_m0_ack, o_m1_ack}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // rst, m0, m1, ack | acc_cyc, m0_ack, m1_ack, grant, acc_adr
    vt.push_back('{1,1,0,0, 0,0,0,2'b00,32'h0});  // M0 read, ack on 4th busy cycle
    vt.push_back('{0,1,0,0, 1,0,0,2'b01,A0});
    vt.push_back('{0,1,0,0, 1,0,0,2'b01,A0});
    vt.push_back('{0,1,0,0, 1,0,0,2'b01,A0});
    vt.push_back('{0,1,0,1, 1,1,0,2'b01,A0});
    vt.push_back('{0,0,0,0, 0,0,0,2'b00,32'h0});
    vt.push_back('{0,0,1,0, 0,0,0,2'b00,32'h0});  // M1 write while M0 idle
    vt.push_back('{0,0,1,0, 1,0,0,2'b10,A1});
    vt.push_back('{0,0,1,1, 1,0,1,2'b10,A1});
    vt.push_back('{0,0,0,0, 0,0,0,2'b00,32'h0});
    vt.push_back('{1,1,1,1, 0,0,0,2'b00,32'h0});  // both held: M0, M1, M0
    vt.push_back('{0,1,1,1, 1,1,0,2'b01,A0});
    vt.push_back('{0,1,1,1, 0,0,0,2'b00,32'h0});
    vt.push_back('{0,1,1,1, 1,0,1,2'b10,A1});
    vt.push_back('{0,1,1,1, 0,0,0,2'b00,32'h0});
    vt.push_back('{0,1,1,1, 1,1,0,2'b01,A0});
    vt.push_back('{1,1,1,0, 0,0,0,2'b00,32'h0});  // M0 aborts, M1 served next
    vt.push_back('{0,1,1,0, 1,0,0,2'b01,A0});
    vt.push_back('{0,0,1,1, 0,0,0,2'b01,A0});
    vt.push_back('{0,0,1,0, 0,0,0,2'b00,32'h0});
    vt.push_back('{0,0,1,0, 1,0,0,2'b10,A1});
    vt.push_back('{0,0,1,1, 1,0,1,2'b10,A1});

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      set_in(vt[i].m0, vt[i].m1, vt[i].ack);
      #1;
      check($sformatf("row%0d acc_cyc", i), 32'(o_acc_cyc), 32'(vt[i].e_cyc));
      check($sformatf("row%0d m0_ack", i), 32'(o_m0_ack), 32'(vt[i].e_a0));
      check($sformatf("row%0d m1_ack", i), 32'(o_m1_ack), 32'(vt[i].e_a1));
      check($sformatf("row%0d grant", i), 32'(o_grant), 32'(vt[i].e_g));
      check($sformatf("row%0d acc_adr", i), o_acc_adr, vt[i].e_adr);
      check($sformatf("row%0d m0_rdt", i), o_m0_rdt, vt[i].e_a0 ? RDT : 32'h0);
      check($sformatf("row%0d m1_rdt", i), o_m1_rdt, vt[i].e_a1 ? RDT : 32'h0);
      check($sformatf("row%0d acc_dat", i), o_acc_dat,
            (vt[i].e_adr == A1) ? D1 : (vt[i].e_adr == A0) ? D0 : 32'h0);
      check($sformatf("row%0d acc_we", i), 32'(o_acc_we), 32'(vt[i].e_adr == A1));
      @(negedge clk);
    end

    // Watchdog: 8th busy cycle without ack terminates with rdt=0
    do_reset();
    set_in(1, 0, 0);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      #1;
      if (k < TO) begin
        check($sformatf("wdt busy%0d acc_cyc", k), 32'(o_acc_cyc), 1);
        check($sformatf("wdt busy%0d m0_ack", k), 32'(o_m0_ack), 0);
      end else begin
        check("wdt expire acc_cyc", 32'(o_acc_cyc), 0);
        check("wdt expire m0_ack", 32'(o_m0_ack), 1);
        check("wdt expire m0_rdt", o_m0_rdt, 0);
        check("wdt expire flag before edge", 32'(o_timeout), 0);
      end
    end
    @(negedge clk);
    set_in(0, 0, 0);
    #1;
    check("wdt flag set", 32'(o_timeout), 1);
    check("wdt grant idle", 32'(o_grant), 0);
    @(negedge clk);
    set_in(1, 0, 0);
    @(negedge clk);
    #1;
    check("post-wdt grant", 32'(o_grant), 1);
    i_acc_ack = 1'b1;
    #1;
    check("post-wdt m0_ack", 32'(o_m0_ack), 1);
    check("post-wdt m0_rdt", o_m0_rdt, RDT);
    @(negedge clk);
    set_in(0, 0, 0);
    #1;
    check("wdt flag sticky", 32'(o_timeout), 1);

    // Ack in the last allowed cycle wins over the watchdog
    do_reset();
    set_in(1, 0, 0);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      if (k == TO) begin
        i_acc_ack = 1'b1;
        #1;
        check("late ack m0_ack", 32'(o_m0_ack), 1);
        check("late ack m0_rdt", o_m0_rdt, RDT);
        check("late ack acc_cyc", 32'(o_acc_cyc), 1);
      end
    end
    @(negedge clk);
    set_in(0, 0, 0);
    #1;
    check("late ack no flag", 32'(o_timeout), 0);

    // Reset while BUSY with M1 holding priority
    do_reset();
    set_in(1, 0, 1);
    @(negedge clk);
    #1;
    check("rst-seq m0 ack", 32'(o_m0_ack), 1);
    @(negedge clk);
    set_in(0, 1, 0);
    @(negedge clk);
    #1;
    check("rst-seq m1 grant", 32'(o_grant), 2);
    i_acc_ack = 1'b1;
    #1;
    check("rst-seq m1 ack pre", 32'(o_m1_ack), 1);
    rst_n = 1'b0;
    #1;
    check("async rst acc_cyc", 32'(o_acc_cyc), 0);
    check("async rst grant", 32'(o_grant), 0);
    check("async rst m1_ack", 32'(o_m1_ack), 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 1, 0);
    @(negedge clk);
    #1;
    check("post-rst priority", 32'(o_grant), 1);

    // Randomized traffic against the reference model
    do_reset();
    owner = -1; last = 1; waited = 0; sticky = 1'b0; thr = 3;
    for (int c = 0; c < 3000; c++) begin
      bit ocyc, done, tmo, ea0, ea1, ecyc, ewe;
      logic [31:0] er0, er1, eadr, edat;
      logic [1:0]  eg;
      if (c % 200 == 0) thr = thr_tab[$urandom_range(0, 2)];
      if ($urandom_range(0, 3) == 0) i_m0_cyc = ~i_m0_cyc;
      if ($urandom_range(0, 3) == 0) i_m1_cyc = ~i_m1_cyc;
      i_acc_ack = ($urandom_range(0, 15) < thr);
      i_m0_adr = $urandom; i_m0_dat = $urandom; i_m0_we = 1'($urandom);
      i_m1_adr = $urandom; i_m1_dat = $urandom; i_m1_we = 1'($urandom);
      i_acc_rdt = $urandom;
      #1;
      done = 0; tmo = 0; ea0 = 0; ea1 = 0; ecyc = 0; ewe = 0;
      er0 = 0; er1 = 0; eadr = 0; edat = 0; eg = 2'b00;
      if (owner >= 0) begin
        bit a;
        logic [31:0] r;
        a = 0; r = 0;
        ocyc = (owner == 0) ? i_m0_cyc : i_m1_cyc;
        eadr = (owner == 0) ? i_m0_adr : i_m1_adr;
        edat = (owner == 0) ? i_m0_dat : i_m1_dat;
        ewe  = (owner == 0) ? i_m0_we : i_m1_we;
        eg   = (owner == 0) ? 2'b01 : 2'b10;
        if (!ocyc) done = 1;
        else if (i_acc_ack) begin a = 1; r = i_acc_rdt; done = 1; end
        else if (TO > 0 && waited == TO - 1) begin a = 1; r = 0; tmo = 1; done = 1; end
        ecyc = ocyc && !tmo;
        if (owner == 0) begin ea0 = a; er0 = r; end
        else begin ea1 = a; er1 = r; end
      end
      act_v = {o_acc_cyc, o_acc_we, o_acc_adr, o_acc_dat, o_m0_ack, o_m0_rdt,
               o_m1_ack, o_m1_rdt, o_grant, o_timeout};
      exp_v = {ecyc, ewe, eadr, edat, ea0, er0, ea1, er1, eg, sticky};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL rand cyc %0d: got %h expected %h", c, act_v, exp_v);
      end
      if (owner < 0) begin
        if (i_m0_cyc || i_m1_cyc) begin
          owner  = (i_m0_cyc && i_m1_cyc) ? 1 - last : (i_m0_cyc ? 0 : 1);
          waited = 0;
        end
      end else if (done) begin
        last  = owner;
        owner = -1;
        if (tmo) sticky = 1'b1;
      end else begin
        waited++;
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
